// File: rtl/qc_parity_accumulator.sv
// Multi-block QC-LDPC parity accumulator: each accepted Z-bit info column is rotated per
// parity block and XOR-folded into NPAR parity registers, framed by first/last with a valid/ready handshake.
module qc_parity_accumulator #(
  parameter int Z      = 5,
  parameter int NPAR   = 4,
  parameter int SW     = $clog2(Z + 1),
  parameter int MAXCOL = 22,
  parameter int CW     = $clog2(MAXCOL + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [Z-1:0]         u,
  input  logic [NPAR*SW-1:0]   shift,
  output logic                 par_valid,
  input  logic                 out_ready,
  output logic [NPAR*Z-1:0]    par_data,
  output logic [CW-1:0]        col_count,
  output logic                 err_seq
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t         state;
  logic [Z-1:0]   acc     [NPAR];
  logic [Z-1:0]   acc_nxt [NPAR];
  logic           accept;

  // Left-rotate by s (bit i lands at (i+s) mod Z); shifts of Z or more are null circulants.
  function automatic logic [Z-1:0] rot(input logic [Z-1:0] x, input logic [SW-1:0] s);
    logic [2*Z-1:0] dbl;
    logic [Z-1:0]   res;
    dbl = {x, x} << s;
    if (s >= SW'(Z)) res = '0;
    else             res = dbl[2*Z-1:Z];
    return res;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    logic [CW-1:0] res;
    if (c >= CW'(MAXCOL)) res = c;
    else                  res = c + CW'(1);
    return res;
  endfunction

  // in_ready depends on state only, so out_ready never reaches it combinationally.
  assign in_ready = (state != DONE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    for (int k = 0; k < NPAR; k++) begin
      acc_nxt[k] = (in_first ? '0 : acc[k]) ^ rot(u, shift[k*SW +: SW]);
    end
  end

  always_comb begin
    par_data = '0;
    for (int k = 0; k < NPAR; k++) begin
      par_data[k*Z +: Z] = acc[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      par_valid <= 1'b0;
      err_seq   <= 1'b0;
      col_count <= '0;
      for (int k = 0; k < NPAR; k++) acc[k] <= '0;
    end else begin
      err_seq <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_first) begin
              for (int k = 0; k < NPAR; k++) acc[k] <= acc_nxt[k];
              col_count <= CW'(1);
              state     <= in_last ? DONE : ACCUM;
              par_valid <= in_last;
            end else begin
              err_seq <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            for (int k = 0; k < NPAR; k++) acc[k] <= acc_nxt[k];
            // A first beat mid-codeword restarts the codeword and is flagged.
            if (in_first) begin
              col_count <= CW'(1);
              err_seq   <= 1'b1;
            end else begin
              col_count <= sat_inc(col_count);
            end
            if (in_last) begin
              state     <= DONE;
              par_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            par_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          par_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
